mcu51_cycle_seq: RTL and testbench

- Machine-cycle timing generator and fetch sequencer for the MCU51 core.
- Divides clk into 8051 machine cycles: 6 states S1..S6, each with phases P1 and P2, so 12 clk per machine cycle.
- Drives ALE, PSEN, the code-ROM chip select, PC increment, IR and operand-register load strobes, and the end-of-instruction execute strobe.
- Sits between the decode half of the control unit, which supplies instruction length and cycle count, and the PC/CODE/IR datapath.

---
 rtl/mcu51_seq_pkg.sv | 50 +++++
 rtl/mcu51_seq_timebase.sv | 61 ++++++
 rtl/mcu51_cycle_seq.sv | 160 ++++++++++++++++
 tb/tb_mcu51_cycle_seq.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu51_seq_pkg.sv
// Shared constants and decode helpers for the MCU51 machine-cycle sequencer.
// Used by mcu51_seq_timebase and mcu51_cycle_seq.
package mcu51_seq_pkg;

    typedef enum logic [2:0] {
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        SEQ_HALT = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_STEP = 2'd2
    } seq_mode_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [3:0] T_SLOTA_BEG = 4'd2;
    localparam logic [3:0] T_SLOTA_END = 4'd5;
    localparam logic [3:0] T_SLOTB_BEG = 4'd8;
    localparam logic [3:0] T_SLOTB_END = 4'd11;
    localparam logic [3:0] T_DECODE    = 4'd6;

    // Machine cycles requested by decode: 00=1, 01=2, 1x=4.
    function automatic logic [2:0] ncycles_decode(input logic [1:0] nc);
        logic [2:0] cnt;
        case (nc)
            2'b00:   cnt = 3'd1;
            2'b01:   cnt = 3'd2;
            default: cnt = 3'd4;
        endcase
        return cnt;
    endfunction

    // Instruction length in bytes; a zero code is a 1-byte instruction.
    function automatic logic [1:0] nbytes_decode(input logic [1:0] nb);
        return (nb == 2'b00) ? 2'd1 : nb;
    endfunction

    // Cycles needed just to fetch len bytes at two fetch slots per cycle.
    function automatic logic [2:0] fetch_cycles(input logic [1:0] len);
        return (len == 2'd3) ? 3'd2 : 3'd1;
    endfunction

endpackage

// File: rtl/mcu51_seq_timebase.sv
// State/phase counter (S1P1..S6P2) for one machine cycle, frozen while held.
// o_wrap pulses on S6P2 so the caller can advance its machine-cycle count.
module mcu51_seq_timebase
    import mcu51_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_hold,
    output logic [2:0] o_state,
    output logic       o_phase,
    output logic [3:0] o_t,
    output logic       o_wrap
);

    seq_state_e r_state;
    logic       r_phase;
    seq_state_e w_state_nxt;
    logic       w_phase_nxt;
    logic [2:0] w_state_l;
    logic [2:0] w_state_m1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S1;
            r_phase <= P1;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        if (!i_hold) begin
            if (r_phase == P1) begin
                w_phase_nxt = P2;
            end else begin
                w_phase_nxt = P1;
                case (r_state)
                    S1:      w_state_nxt = S2;
                    S2:      w_state_nxt = S3;
                    S3:      w_state_nxt = S4;
                    S4:      w_state_nxt = S5;
                    S5:      w_state_nxt = S6;
                    S6:      w_state_nxt = S1;
                    default: w_state_nxt = S1;
                endcase
            end
        end
    end

    // Slot index t = (state-1)*2 + phase is just {state-1, phase}.
    assign w_state_l  = r_state;
    assign w_state_m1 = w_state_l - 3'd1;
    assign o_state    = w_state_l;
    assign o_phase    = r_phase;
    assign o_t        = {w_state_m1, r_phase};
    assign o_wrap     = !i_hold && (r_state == S6) && (r_phase == P2);

endmodule

// File: rtl/mcu51_cycle_seq.sv
// MCU51 machine-cycle timing generator and fetch sequencer (12 clk per cycle).
// Optional single-step input is enabled by defining MCU51_SEQ_STEP_EN.
module mcu51_cycle_seq
    import mcu51_seq_pkg::*;
#(
    parameter int MAXCYC_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                ea,
    input  logic [1:0]          ncycles,
    input  logic [1:0]          nbytes,
`ifdef MCU51_SEQ_STEP_EN
    input  logic                step,
`endif
    output logic [2:0]          state,
    output logic                phase,
    output logic [MAXCYC_W-1:0] mcycle,
    output logic                ALE,
    output logic                PSEN,
    output logic                code_cs,
    output logic                pc_en,
    output logic                ir_en,
    output logic [1:0]          opnd_en,
    output logic                exec_en,
    output logic                instr_done,
    output logic                halted
);

    seq_mode_e           r_mode;
    seq_mode_e           w_mode_nxt;
    logic [MAXCYC_W-1:0] r_mcycle;
    logic [1:0]          r_byte_idx;
    logic [1:0]          r_len;
    logic [MAXCYC_W-1:0] r_last_mc;

    logic                w_step;
    logic                w_active;
    logic [3:0]          w_t;
    logic                w_wrap;
    logic [1:0]          w_len;
    logic                w_slot;
    logic                w_slot_end;
    logic                w_fetch;
    logic                w_pc;
    logic                w_end;
    logic                w_latch;
    logic                w_ale;
    logic [2:0]          w_eff_cyc;
    logic [2:0]          w_dec_cyc;
    logic [2:0]          w_len_cyc;

`ifdef MCU51_SEQ_STEP_EN
    assign w_step = step;
`else
    assign w_step = 1'b0;
`endif

    assign w_active = (r_mode != SEQ_HALT);

    mcu51_seq_timebase u_timebase (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (!w_active),
        .o_state (state),
        .o_phase (phase),
        .o_t     (w_t),
        .o_wrap  (w_wrap)
    );

    // Until decode is latched, assume a second byte exists; only byte 0 is
    // actually reachable before then, so this never over-fetches.
    assign w_len = ((r_mcycle == '0) && (w_t <= T_DECODE)) ? 2'd2 : r_len;

    assign w_dec_cyc = ncycles_decode(ncycles);
    assign w_len_cyc = fetch_cycles(nbytes_decode(nbytes));
    assign w_eff_cyc = (w_dec_cyc > w_len_cyc) ? w_dec_cyc : w_len_cyc;

    always_comb begin
        w_mode_nxt = r_mode;
        w_slot     = 1'b0;
        w_slot_end = 1'b0;
        w_fetch    = 1'b0;
        w_pc       = 1'b0;
        w_end      = 1'b0;
        w_latch    = 1'b0;
        w_ale      = 1'b0;

        if (w_active) begin
            w_slot     = ((w_t >= T_SLOTA_BEG) && (w_t <= T_SLOTA_END)) ||
                         ((w_t >= T_SLOTB_BEG) && (w_t <= T_SLOTB_END));
            w_slot_end = (w_t == T_SLOTA_END) || (w_t == T_SLOTB_END);
            w_fetch    = w_slot && (r_byte_idx < w_len);
            w_pc       = w_fetch && w_slot_end;
            w_end      = (w_t == T_SLOTB_END) && (r_mcycle == r_last_mc);
            w_latch    = (r_mcycle == '0) && (w_t == T_DECODE);
            w_ale      = (w_t == 4'd1) || (w_t == 4'd2) ||
                         (w_t == 4'd7) || (w_t == 4'd8);
        end

        case (r_mode)
            SEQ_HALT: begin
                if (run)
                    w_mode_nxt = SEQ_RUN;
                else if (w_step)
                    w_mode_nxt = SEQ_STEP;
            end
            SEQ_RUN: begin
                if (w_end)
                    w_mode_nxt = run ? SEQ_RUN : SEQ_HALT;
            end
            SEQ_STEP: begin
                if (w_end)
                    w_mode_nxt = SEQ_HALT;
            end
            default: w_mode_nxt = SEQ_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_mode     <= SEQ_HALT;
            r_mcycle   <= '0;
            r_byte_idx <= 2'd0;
        end else begin
            r_mode <= w_mode_nxt;
            if (w_end) begin
                r_mcycle   <= '0;
                r_byte_idx <= 2'd0;
            end else begin
                if (w_wrap)
                    r_mcycle <= r_mcycle + 1'b1;
                if (w_pc)
                    r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    // Decode results are captured once per instruction, after IR is valid.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_len     <= nbytes_decode(nbytes);
            r_last_mc <= MAXCYC_W'(w_eff_cyc - 3'd1);
        end
    end

    assign mcycle     = r_mcycle;
    assign halted     = !w_active;
    assign ALE        = w_ale;
    assign code_cs    = w_fetch;
    assign PSEN       = !(w_fetch && !ea);
    assign pc_en      = w_pc;
    assign ir_en      = w_pc && (r_byte_idx == 2'd0);
    assign opnd_en[0] = w_pc && (r_byte_idx == 2'd1);
    assign opnd_en[1] = w_pc && (r_byte_idx == 2'd2);
    assign exec_en    = w_end;
    assign instr_done = w_end;

endmodule

// File: tb/tb_mcu51_cycle_seq.sv
// Directed-vector bench for mcu51_cycle_seq; step scenario runs when
// MCU51_SEQ_STEP_EN is defined.
module tb_mcu51_cycle_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       ea;
    logic [1:0] ncycles;
    logic [1:0] nbytes;
`ifdef MCU51_SEQ_STEP_EN
    logic       step;
`endif
    logic [2:0] state;
    logic       phase;
    logic [1:0] mcycle;
    logic       ALE, PSEN, code_cs, pc_en, ir_en, exec_en, instr_done, halted;
    logic [1:0] opnd_en;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mcu51_cycle_seq #(.MAXCYC_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .ea         (ea),
        .ncycles    (ncycles),
        .nbytes     (nbytes),
`ifdef MCU51_SEQ_STEP_EN
        .step       (step),
`endif
        .state      (state),
        .phase      (phase),
        .mcycle     (mcycle),
        .ALE        (ALE),
        .PSEN       (PSEN),
        .code_cs    (code_cs),
        .pc_en      (pc_en),
        .ir_en      (ir_en),
        .opnd_en    (opnd_en),
        .exec_en    (exec_en),
        .instr_done (instr_done),
        .halted     (halted)
    );

    // {ALE, PSEN, code_cs, pc_en, ir_en, opnd_en[1:0], exec_en, instr_done, halted}
    logic [9:0] obs;
    logic [5:0] obs_pos;
    assign obs     = {ALE, PSEN, code_cs, pc_en, ir_en, opnd_en, exec_en, instr_done, halted};
    assign obs_pos = {state, phase, mcycle};

    localparam logic [9:0] IDLE_VEC = 10'b0100000001;
    localparam logic [5:0] POS0     = 6'b001_0_00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b1; ea = 1'b1; ncycles = 2'b00; nbytes = 2'b01;
        tick();
        tick();
        n_tests++;
        if (obs !== IDLE_VEC) begin
            n_fail++;
            $display("FAIL reset_strobes got %b want %b", obs, IDLE_VEC);
        end
        n_tests++;
        if (obs_pos !== POS0) begin
            n_fail++;
            $display("FAIL reset_pos got %b want %b", obs_pos, POS0);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (halted !== 1'b0 || obs_pos !== POS0) begin
            n_fail++;
            $display("FAIL reset_release got halted=%b pos=%b want halted=0 pos=%b",
                     halted, obs_pos, POS0);
        end
    endtask

    // Two back-to-back 1-byte, 1-cycle instructions from internal ROM.
    task automatic test_back_to_back();
        int t;
        logic e_ale, e_cs, e_pc, e_ex;
        logic [9:0] exp;
        logic [5:0] pos;
        for (int k = 0; k < 24; k++) begin
            t     = k % 12;
            e_ale = (t == 1 || t == 2 || t == 7 || t == 8);
            e_cs  = (t >= 2 && t <= 5);
            e_pc  = (t == 5);
            e_ex  = (t == 11);
            exp   = {e_ale, 1'b1, e_cs, e_pc, e_pc, 2'b00, e_ex, e_ex, 1'b0};
            pos   = {3'(t / 2 + 1), 1'(t % 2), 2'd0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b_strobes k=%0d got %b want %b", k, obs, exp);
            end
            n_tests++;
            if (obs_pos !== pos) begin
                n_fail++;
                $display("FAIL b2b_pos k=%0d got %b want %b", k, obs_pos, pos);
            end
            tick();
        end
    endtask

    // 2-byte, 1-cycle instructions from external ROM.
    task automatic test_two_byte();
        int t;
        logic e_ale, e_cs, e_pc, e_ir, e_o0, e_ex;
        logic [9:0] exp;
        ea = 1'b0; nbytes = 2'b10; ncycles = 2'b00;
        for (int k = 0; k < 24; k++) begin
            t     = k % 12;
            e_ale = (t == 1 || t == 2 || t == 7 || t == 8);
            e_cs  = (t >= 2 && t <= 5) || (t >= 8);
            e_pc  = (t == 5 || t == 11);
            e_ir  = (t == 5);
            e_o0  = (t == 11);
            e_ex  = (t == 11);
            exp   = {e_ale, !e_cs, e_cs, e_pc, e_ir, 1'b0, e_o0, e_ex, e_ex, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL two_byte k=%0d got %b want %b", k, obs, exp);
            end
            tick();
        end
    endtask

    // 3-byte instruction with ncycles=00 stretches to 2 machine cycles.
    task automatic test_stretch();
        int t, mc, n_pc;
        logic e_ale, e_cs, e_pc, e_ir, e_o0, e_o1, e_ex;
        logic [9:0] exp;
        nbytes = 2'b11; ncycles = 2'b00;
        n_pc = 0;
        for (int k = 0; k < 24; k++) begin
            t     = k % 12;
            mc    = k / 12;
            e_ale = (t == 1 || t == 2 || t == 7 || t == 8);
            e_cs  = (t >= 2 && t <= 5) || (mc == 0 && t >= 8);
            e_pc  = (t == 5) || (mc == 0 && t == 11);
            e_ir  = (mc == 0 && t == 5);
            e_o0  = (mc == 0 && t == 11);
            e_o1  = (mc == 1 && t == 5);
            e_ex  = (mc == 1 && t == 11);
            exp   = {e_ale, !e_cs, e_cs, e_pc, e_ir, e_o1, e_o0, e_ex, e_ex, 1'b0};
            if (pc_en === 1'b1) n_pc++;
            n_tests++;
            if (obs !== exp || mcycle !== 2'(mc)) begin
                n_fail++;
                $display("FAIL stretch k=%0d got %b mc=%0d want %b mc=%0d",
                         k, obs, mcycle, exp, mc);
            end
            tick();
        end
        n_tests++;
        if (n_pc !== 3) begin
            n_fail++;
            $display("FAIL stretch_pc_count got %0d want 3", n_pc);
        end
    endtask

    // 4-cycle, 1-byte instruction: one fetch, exec at end of mcycle 3.
    task automatic test_four_cycle();
        int t, mc, n_pc;
        logic e_ale, e_cs, e_ex;
        logic [9:0] exp;
        nbytes = 2'b01; ncycles = 2'b10;
        n_pc = 0;
        for (int k = 0; k < 48; k++) begin
            t     = k % 12;
            mc    = k / 12;
            e_ale = (t == 1 || t == 2 || t == 7 || t == 8);
            e_cs  = (mc == 0 && t >= 2 && t <= 5);
            e_ex  = (k == 47);
            exp   = {e_ale, !e_cs, e_cs, (k == 5), (k == 5), 2'b00, e_ex, e_ex, 1'b0};
            if (pc_en === 1'b1) n_pc++;
            n_tests++;
            if (obs !== exp || mcycle !== 2'(mc)) begin
                n_fail++;
                $display("FAIL four_cycle k=%0d got %b mc=%0d want %b mc=%0d",
                         k, obs, mcycle, exp, mc);
            end
            tick();
        end
        n_tests++;
        if (n_pc !== 1) begin
            n_fail++;
            $display("FAIL four_cycle_pc_count got %0d want 1", n_pc);
        end
    endtask

    // run drops early in a 2-cycle instruction; it completes, then halts.
    task automatic test_run_drop();
        int t, mc;
        logic h, e_ale, e_cs, e_ex;
        logic [9:0] exp;
        logic [5:0] pos;
        nbytes = 2'b01; ncycles = 2'b01;
        for (int k = 0; k < 30; k++) begin
            h     = (k >= 24);
            t     = h ? 0 : k % 12;
            mc    = h ? 0 : k / 12;
            e_ale = !h && (t == 1 || t == 2 || t == 7 || t == 8);
            e_cs  = !h && mc == 0 && t >= 2 && t <= 5;
            e_ex  = (k == 23);
            exp   = {e_ale, !e_cs, e_cs, (k == 5), (k == 5), 2'b00, e_ex, e_ex, h};
            pos   = {3'(t / 2 + 1), 1'(t % 2), 2'(mc)};
            n_tests++;
            if (obs !== exp || obs_pos !== pos) begin
                n_fail++;
                $display("FAIL run_drop k=%0d got %b/%b want %b/%b",
                         k, obs, obs_pos, exp, pos);
            end
            if (k == 3) run = 1'b0;
            tick();
        end
    endtask

    // Reset at mcycle 1, t=4 of a 2-cycle instruction aborts it.
    task automatic test_reset_mid();
        logic [9:0] exp;
        run = 1'b1;
        tick();
        for (int k = 0; k < 17; k++) begin
            exp = {(k % 12 == 1 || k % 12 == 2 || k % 12 == 7 || k % 12 == 8),
                   !(k >= 2 && k <= 5), (k >= 2 && k <= 5),
                   (k == 5), (k == 5), 2'b00, 1'b0, 1'b0, 1'b0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL pre_abort k=%0d got %b want %b", k, obs, exp);
            end
            if (k == 16) reset = 1'b0;
            else tick();
        end
        tick();
        n_tests++;
        if (obs !== IDLE_VEC || obs_pos !== POS0) begin
            n_fail++;
            $display("FAIL reset_abort got %b/%b want %b/%b", obs, obs_pos, IDLE_VEC, POS0);
        end
        reset = 1'b1; run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (obs !== IDLE_VEC || obs_pos !== POS0) begin
                n_fail++;
                $display("FAIL halt_hold k=%0d got %b/%b want %b/%b",
                         k, obs, obs_pos, IDLE_VEC, POS0);
            end
        end
    endtask

`ifdef MCU51_SEQ_STEP_EN
    task automatic test_step();
        int n_ir, n_ex;
        nbytes = 2'b01; ncycles = 2'b00; run = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            n_tests++;
            if (halted !== 1'b0 || obs_pos !== POS0) begin
                n_fail++;
                $display("FAIL step_start rep=%0d got halted=%b pos=%b want 0/%b",
                         rep, halted, obs_pos, POS0);
            end
            n_ir = 0; n_ex = 0;
            for (int k = 0; k < 16; k++) begin
                if (ir_en === 1'b1) n_ir++;
                if (exec_en === 1'b1) n_ex++;
                tick();
            end
            n_tests++;
            if (n_ir !== 1 || n_ex !== 1) begin
                n_fail++;
                $display("FAIL step_count rep=%0d got ir=%0d exec=%0d want 1/1", rep, n_ir, n_ex);
            end
            n_tests++;
            if (obs !== IDLE_VEC || obs_pos !== POS0) begin
                n_fail++;
                $display("FAIL step_rehalt rep=%0d got %b/%b want %b/%b",
                         rep, obs, obs_pos, IDLE_VEC, POS0);
            end
        end
    endtask
`endif

    initial begin
`ifdef MCU51_SEQ_STEP_EN
        step = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_two_byte();
        test_stretch();
        test_four_cycle();
        test_run_drop();
        test_reset_mid();
`ifdef MCU51_SEQ_STEP_EN
        test_step();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
